// File: rtl/parity_pkg.sv
// Shared types for the serial parity checker.
// State encoding used by the frame FSM.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR cell.
// Folds one serial bit into the running parity.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/parity_checker.sv
// Serial frame receiver with parity check.
// LSB-first data bits, then one parity bit.
import parity_pkg::*;

module parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         busy,
  output logic                         done,
  output logic                         parity_err,
  output logic [DATA_BITS-1:0]         data_out,
  output logic [$clog2(DATA_BITS+1)-1:0] bit_count
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
  localparam logic ODD = 1'(ODD_PARITY);

  state_e                 state_q;
  logic                   acc_q;
  logic                   acc_d;
  logic                   perr_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [DATA_BITS-1:0]   data_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;

  xor_gate u_xor (
    .a (acc_q),
    .b (bit_in),
    .y (acc_d)
  );

  // Place the incoming bit at its position and advance the count.
  always_comb begin
    data_d = data_q | (DATA_BITS'(bit_in) << cnt_q);
    cnt_d  = cnt_q + CW'(1);
  end

  // Frame FSM; abort outranks any bit offered in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_DATA;
            acc_q   <= 1'b0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
          end
        end
        ST_DATA: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (bit_valid) begin
            data_q <= data_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            if (cnt_q == LAST)
              state_q <= ST_PAR;
          end
        end
        ST_PAR: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (bit_valid) begin
            perr_q  <= acc_d ^ ODD;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q == ST_DATA) || (state_q == ST_PAR);
  assign done       = (state_q == ST_DONE);
  assign parity_err = perr_q;
  assign data_out   = data_q;
  assign bit_count  = cnt_q;

endmodule
